// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decoder: opcode values, instruction field
// positions and the decode FSM state encoding.
package isa_pkg;

    localparam int IMM_W  = 6;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 6;
    localparam int RS2_HI = 5;
    localparam int RS2_LO = 3;
    localparam int IMM_HI = 5;
    localparam int IMM_LO = 0;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_ANDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_DISPATCH  = 3'd2,
        S_WAIT_RES  = 3'd3,
        S_WRITEBACK = 3'd4
    } state_e;

    // Opcodes 8-15 are undefined; the top bit alone identifies them.
    function automatic logic op_illegal(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic op_uses_imm(input logic [3:0] op);
        return op[2] & ~op[3];
    endfunction

endpackage

// File: rtl/imm_ext.sv
// Sign-extends the 6-bit instruction immediate to the datapath width.
module imm_ext
    import isa_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [IMM_W-1:0]  imm6,
    output logic [DATA_W-1:0] imm_out
);

    assign imm_out = {{(DATA_W-IMM_W){imm6[IMM_W-1]}}, imm6};

endmodule

// File: rtl/instr_decode.sv
// Multi-cycle instruction decoder: accepts one instruction, reads operands,
// dispatches to execute, waits for the result and writes it back.
module instr_decode
    import isa_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr,
    output logic              instr_ready,
    output logic [2:0]        rf_addr1,
    output logic [2:0]        rf_addr2,
    output logic [2:0]        rf_addr3,
    output logic              rf_regwr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [3:0]        ex_op,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_use_imm,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [2:0]        rf_addr1_q, rf_addr1_d;
    logic [2:0]        rf_addr2_q, rf_addr2_d;
    logic [2:0]        rf_addr3_q, rf_addr3_d;
    logic [3:0]        ex_op_q, ex_op_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic              ex_use_imm_q, ex_use_imm_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        opcode;
    logic [DATA_W-1:0] imm_sext;

    assign opcode = instr[OPC_HI:OPC_LO];

    imm_ext #(.DATA_W(DATA_W)) u_imm_ext (
        .imm6    (instr[IMM_HI:IMM_LO]),
        .imm_out (imm_sext)
    );

    always_comb begin
        state_d      = state_q;
        rf_addr1_d   = rf_addr1_q;
        rf_addr2_d   = rf_addr2_q;
        rf_addr3_d   = rf_addr3_q;
        ex_op_d      = ex_op_q;
        ex_imm_d     = ex_imm_q;
        ex_use_imm_d = ex_use_imm_q;
        rf_wdata_d   = rf_wdata_q;
        illegal_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    if (op_illegal(opcode)) begin
                        illegal_d = 1'b1;
                    end else begin
                        rf_addr1_d   = instr[RS1_HI:RS1_LO];
                        // Stores read the data register through port 2.
                        rf_addr2_d   = (opcode == OP_SW) ? instr[RD_HI:RD_LO]
                                                         : instr[RS2_HI:RS2_LO];
                        rf_addr3_d   = instr[RD_HI:RD_LO];
                        ex_op_d      = opcode;
                        ex_imm_d     = imm_sext;
                        ex_use_imm_d = op_uses_imm(opcode);
                        state_d      = S_READ;
                    end
                end
            end
            S_READ: state_d = S_DISPATCH;
            S_DISPATCH: begin
                if (ex_ready) state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (res_valid) begin
                    rf_wdata_d = res_data;
                    state_d    = (ex_op_q == OP_SW) ? S_IDLE : S_WRITEBACK;
                end
            end
            S_WRITEBACK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rf_addr1_q   <= '0;
            rf_addr2_q   <= '0;
            rf_addr3_q   <= '0;
            ex_op_q      <= '0;
            ex_imm_q     <= '0;
            ex_use_imm_q <= 1'b0;
            rf_wdata_q   <= '0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rf_addr1_q   <= rf_addr1_d;
            rf_addr2_q   <= rf_addr2_d;
            rf_addr3_q   <= rf_addr3_d;
            ex_op_q      <= ex_op_d;
            ex_imm_q     <= ex_imm_d;
            ex_use_imm_q <= ex_use_imm_d;
            rf_wdata_q   <= rf_wdata_d;
            illegal_q    <= illegal_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign ex_valid    = (state_q == S_DISPATCH);
    // Register r0 is hardwired, so a writeback to it is dropped.
    assign rf_regwr    = (state_q == S_WRITEBACK) && (rf_addr3_q != 3'd0);
    assign rf_addr1    = rf_addr1_q;
    assign rf_addr2    = rf_addr2_q;
    assign rf_addr3    = rf_addr3_q;
    assign rf_wdata    = rf_wdata_q;
    assign ex_op       = ex_op_q;
    assign ex_imm      = ex_imm_q;
    assign ex_use_imm  = ex_use_imm_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction model.
module tb_instr_decode;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [2:0]  rf_addr1, rf_addr2, rf_addr3;
    logic        rf_regwr;
    logic [15:0] rf_wdata;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_op;
    logic [15:0] ex_imm;
    logic        ex_use_imm;
    logic        res_valid;
    logic [15:0] res_data;
    logic        illegal;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Transaction-level reference: one in-flight instruction and its progress.
    bit          m_active, m_sent, m_wb, m_illegal;
    int          m_age;
    logic [3:0]  m_op;
    logic [2:0]  m_rd, m_rs1, m_addr2;
    logic [15:0] m_imm, m_wdata;

    instr_decode #(.DATA_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_addr1    (rf_addr1),
        .rf_addr2    (rf_addr2),
        .rf_addr3    (rf_addr3),
        .rf_regwr    (rf_regwr),
        .rf_wdata    (rf_wdata),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_op       (ex_op),
        .ex_imm      (ex_imm),
        .ex_use_imm  (ex_use_imm),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        int s;
        s = int'(v);
        if (s >= 32) s = s - 64;
        return 16'(s);
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic iv, input logic [15:0] ins,
                                 input logic er, input logic rv, input logic [15:0] rd);
        rst         = r;
        instr_valid = iv;
        instr       = ins;
        ex_ready    = er;
        res_valid   = rv;
        res_data    = rd;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_sent = 0; m_wb = 0; m_illegal = 0; m_age = 0;
            m_op = '0; m_rd = '0; m_rs1 = '0; m_addr2 = '0; m_imm = '0; m_wdata = '0;
        end else begin
            m_illegal = 0;
            if (!m_active) begin
                if (instr_valid) begin
                    if (instr[15:12] >= 4'd8) begin
                        m_illegal = 1;
                    end else begin
                        m_active = 1; m_sent = 0; m_wb = 0; m_age = 1;
                        m_op    = instr[15:12];
                        m_rd    = instr[11:9];
                        m_rs1   = instr[8:6];
                        m_addr2 = (instr[15:12] == 4'd7) ? instr[11:9] : instr[5:3];
                        m_imm   = sext6(instr[5:0]);
                    end
                end
            end else if (m_wb) begin
                m_wb = 0;
                m_active = 0;
            end else if (!m_sent) begin
                if (m_age >= 2 && ex_ready) m_sent = 1;
                m_age++;
            end else if (res_valid) begin
                m_wdata = res_data;
                if (m_op == 4'd7) m_active = 0;
                else m_wb = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("instr_ready", 16'(instr_ready), 16'(!m_active));
            checkOutput("ex_valid", 16'(ex_valid), 16'(m_active && !m_wb && !m_sent && m_age >= 2));
            checkOutput("rf_regwr", 16'(rf_regwr), 16'(m_wb && m_rd != 3'd0));
            checkOutput("illegal", 16'(illegal), 16'(m_illegal));
            checkOutput("rf_addr1", 16'(rf_addr1), 16'(m_rs1));
            checkOutput("rf_addr2", 16'(rf_addr2), 16'(m_addr2));
            checkOutput("rf_addr3", 16'(rf_addr3), 16'(m_rd));
            checkOutput("ex_op", 16'(ex_op), 16'(m_op));
            checkOutput("ex_imm", ex_imm, m_imm);
            checkOutput("ex_use_imm", 16'(ex_use_imm), 16'(m_op >= 4'd4));
            checkOutput("rf_wdata", rf_wdata, m_wdata);
        end
    end

    initial begin
        logic [3:0] op;
        rst = 1; instr_valid = 0; instr = '0; ex_ready = 0; res_valid = 0; res_data = '0;

        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0);
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0);
        chk_en = 1;
        checkOutput("rst_instr_ready", 16'(instr_ready), 16'd1);
        checkOutput("rst_ex_valid", 16'(ex_valid), 16'd0);
        checkOutput("rst_rf_wdata", rf_wdata, 16'd0);

        $display("[TB] ADD r3,r1,r2");
        applyStimulus(0, 1, 16'h0650, 1, 0, 16'h0);
        checkOutput("add_read_ex_valid", 16'(ex_valid), 16'd0);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0);
        checkOutput("add_ex_valid", 16'(ex_valid), 16'd1);
        checkOutput("add_addr1", 16'(rf_addr1), 16'd1);
        checkOutput("add_addr2", 16'(rf_addr2), 16'd2);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 1, 16'd25);
        checkOutput("add_regwr", 16'(rf_regwr), 16'd1);
        checkOutput("add_addr3", 16'(rf_addr3), 16'd3);
        checkOutput("add_wdata", rf_wdata, 16'd25);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0);
        checkOutput("add_done_regwr", 16'(rf_regwr), 16'd0);

        $display("[TB] ADDI r4,r1,-1");
        applyStimulus(0, 1, 16'h487F, 1, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0);
        checkOutput("addi_ex_imm", ex_imm, 16'hFFFF);
        checkOutput("addi_use_imm", 16'(ex_use_imm), 16'd1);
        checkOutput("addi_ex_op", 16'(ex_op), 16'd4);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 1, 16'd9);
        checkOutput("addi_regwr", 16'(rf_regwr), 16'd1);
        checkOutput("addi_addr3", 16'(rf_addr3), 16'd4);
        checkOutput("addi_wdata", rf_wdata, 16'd9);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0);

        $display("[TB] illegal 0x9000");
        applyStimulus(0, 1, 16'h9000, 1, 0, 16'h0);
        checkOutput("ill_pulse", 16'(illegal), 16'd1);
        checkOutput("ill_ready", 16'(instr_ready), 16'd1);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0);
        checkOutput("ill_pulse_end", 16'(illegal), 16'd0);
        checkOutput("ill_ex_valid", 16'(ex_valid), 16'd0);

        $display("[TB] ADD r0,r1,r2");
        applyStimulus(0, 1, 16'h0050, 1, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 1, 16'd25);
        checkOutput("r0_regwr", 16'(rf_regwr), 16'd0);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0);
        checkOutput("r0_idle", 16'(instr_ready), 16'd1);

        $display("[TB] dispatch stall");
        applyStimulus(0, 1, 16'h0650, 0, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_ex_valid", 16'(ex_valid), 16'd1);
            checkOutput("stall_addr1", 16'(rf_addr1), 16'd1);
            applyStimulus(0, 0, 16'h0, (i == 3), 0, 16'h0);
        end
        checkOutput("stall_after_xfer", 16'(ex_valid), 16'd0);
        applyStimulus(0, 0, 16'h0, 0, 1, 16'd7);
        applyStimulus(0, 0, 16'h0, 0, 0, 16'h0);

        $display("[TB] reset in WAIT_RES");
        applyStimulus(0, 1, 16'h0650, 1, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0);
        applyStimulus(0, 0, 16'h0, 1, 0, 16'h0);
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0);
        checkOutput("rstw_ready", 16'(instr_ready), 16'd1);
        applyStimulus(0, 0, 16'h0, 0, 1, 16'd25);
        checkOutput("rstw_regwr", 16'(rf_regwr), 16'd0);
        checkOutput("rstw_ready2", 16'(instr_ready), 16'd1);
        checkOutput("rstw_wdata", rf_wdata, 16'd0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            op = ($urandom_range(0, 4) == 0) ? 4'(8 + $urandom_range(0, 7))
                                            : 4'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 99) == 0), $urandom_range(0, 1),
                          {op, 12'($urandom)}, $urandom_range(0, 1),
                          ($urandom_range(0, 2) == 0), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
